// File: rtl/testing_cpu_mulx_seq.sv
// Multi-cycle 32x32 multiply sequencer built around one registered 16x16 unsigned multiplier.
// Optional build macro TESTING_CPU_MULX_EARLY_OUT_EN: MUL skips pp3 and the high-word fix.
module testing_cpu_mulx_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        M_mulx_req_valid,
    output logic        M_mulx_req_ready,
    input  logic [1:0]  M_mulx_op,
    input  logic [31:0] M_mulx_src1,
    input  logic [31:0] M_mulx_src2,
    input  logic        M_mulx_abort,
    output logic        M_mulx_result_valid,
    output logic [31:0] M_mulx_result
);

    localparam int DATA_W = 32;
    localparam int HALF_W = DATA_W / 2;
    localparam int ACC_W  = 2 * DATA_W;

    localparam logic [1:0] OP_MUL    = 2'd0;
    localparam logic [1:0] OP_MULXSU = 2'd2;
    localparam logic [1:0] OP_MULXSS = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FIX,
        S_DONE
    } state_t;

    state_t                    state;
    logic [1:0]                cnt;
    logic [1:0]                op_p0;
    logic signed [DATA_W-1:0]  a_p0;
    logic signed [DATA_W-1:0]  b_p0;
    logic [DATA_W-1:0]         prod_p1;
    logic [1:0]                sh_p1;
    logic                      vld_p1;
    logic [ACC_W-1:0]          acc_p2;

    logic [HALF_W-1:0]         a_half;
    logic [HALF_W-1:0]         b_half;
    logic [DATA_W-1:0]         pp_p0;
    logic [ACC_W-1:0]          acc_sum;
    logic [DATA_W-1:0]         hi_fixed;
    logic                      issue_last;

    // Converts the unsigned high word into the signed-operand high word.
    function automatic logic [DATA_W-1:0] fix_hi(input logic [1:0] op,
                                                 input logic [DATA_W-1:0] hi,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        r = hi;
        if ((op == OP_MULXSU || op == OP_MULXSS) && a[DATA_W-1])
            r = r - b;
        if (op == OP_MULXSS && b[DATA_W-1])
            r = r - a;
        return r;
    endfunction

    always_comb begin
        a_half   = cnt[0] ? a_p0[DATA_W-1:HALF_W] : a_p0[HALF_W-1:0];
        b_half   = cnt[1] ? b_p0[DATA_W-1:HALF_W] : b_p0[HALF_W-1:0];
        pp_p0    = {{HALF_W{1'b0}}, a_half} * {{HALF_W{1'b0}}, b_half};
        acc_sum  = acc_p2 + ({{DATA_W{1'b0}}, prod_p1} << {sh_p1, 4'b0000});
        hi_fixed = fix_hi(op_p0, acc_p2[ACC_W-1:DATA_W], a_p0, b_p0);
`ifdef TESTING_CPU_MULX_EARLY_OUT_EN
        issue_last = (op_p0 == OP_MUL) ? (cnt == 2'd2) : (cnt == 2'd3);
`else
        issue_last = (cnt == 2'd3);
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= S_IDLE;
            cnt                 <= 2'd0;
            op_p0               <= 2'd0;
            a_p0                <= '0;
            b_p0                <= '0;
            prod_p1             <= '0;
            sh_p1               <= 2'd0;
            vld_p1              <= 1'b0;
            acc_p2              <= '0;
            M_mulx_req_ready    <= 1'b1;
            M_mulx_result_valid <= 1'b0;
            M_mulx_result       <= '0;
        end else begin
            vld_p1              <= 1'b0;
            M_mulx_result_valid <= 1'b0;
            // --- accumulate stage: product issued last cycle lands in acc ---
            if (vld_p1)
                acc_p2 <= acc_sum;

            unique case (state)
                S_IDLE: begin
                    if (M_mulx_req_valid) begin
                        op_p0            <= M_mulx_op;
                        a_p0             <= M_mulx_src1;
                        b_p0             <= M_mulx_src2;
                        acc_p2           <= '0;
                        cnt              <= 2'd0;
                        state            <= S_ISSUE;
                        M_mulx_req_ready <= 1'b0;
                    end
                end
                // --- issue stage: one partial product into the multiplier ---
                S_ISSUE: begin
                    if (M_mulx_abort) begin
                        state            <= S_IDLE;
                        M_mulx_req_ready <= 1'b1;
                    end else begin
                        prod_p1 <= pp_p0;
                        sh_p1   <= {1'b0, cnt[0]} + {1'b0, cnt[1]};
                        vld_p1  <= 1'b1;
                        if (issue_last)
                            state <= S_DRAIN;
                        else
                            cnt <= cnt + 2'd1;
                    end
                end
                S_DRAIN: begin
                    if (M_mulx_abort) begin
                        state            <= S_IDLE;
                        M_mulx_req_ready <= 1'b1;
                    end else begin
`ifdef TESTING_CPU_MULX_EARLY_OUT_EN
                        if (op_p0 == OP_MUL) begin
                            M_mulx_result       <= acc_sum[DATA_W-1:0];
                            M_mulx_result_valid <= 1'b1;
                            state               <= S_DONE;
                        end else begin
                            state <= S_FIX;
                        end
`else
                        state <= S_FIX;
`endif
                    end
                end
                // --- fix stage: signed high-word correction and result select ---
                S_FIX: begin
                    if (M_mulx_abort) begin
                        state            <= S_IDLE;
                        M_mulx_req_ready <= 1'b1;
                    end else begin
                        acc_p2[ACC_W-1:DATA_W] <= hi_fixed;
                        M_mulx_result          <= (op_p0 == OP_MUL) ? acc_p2[DATA_W-1:0] : hi_fixed;
                        M_mulx_result_valid    <= 1'b1;
                        state                  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state            <= S_IDLE;
                    M_mulx_req_ready <= 1'b1;
                end
                default: begin
                    state            <= S_IDLE;
                    M_mulx_req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/testing_cpu_mulx_seq.md
# testing_CPU_mulx_seq

Multi-cycle multiply sequencer for the CPU M-stage. It computes the full 32x32 product for MUL, MULXUU, MULXSU and MULXSS through one shared, registered 16x16 unsigned multiplier. It issues four partial products, accumulates them into a 64-bit sum, applies the signed high-word correction, and returns the selected 32-bit word. It sits between the M-stage control and the writeback mux, alongside the single-cycle multiply cell.

## Interface
Parameters:
- None.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- M_mulx_req_valid  in  1  request strobe, sampled only when M_mulx_req_ready=1.
- M_mulx_req_ready  out  1  high exactly when state is IDLE.
- M_mulx_op  in  2  operation select:
  - 0 = MUL (low word of product).
  - 1 = MULXUU (high word, both operands unsigned).
  - 2 = MULXSU (high word, src1 signed, src2 unsigned).
  - 3 = MULXSS (high word, both operands signed).
- M_mulx_src1  in  32  operand A, latched on acceptance.
- M_mulx_src2  in  32  operand B, latched on acceptance.
- M_mulx_abort  in  1  synchronous cancel of the operation in flight.
- M_mulx_result_valid  out  1  one-cycle pulse; M_mulx_result is valid in that cycle.
- M_mulx_result  out  32  registered result; holds its value until the next DONE.

## Operation
- States: IDLE, ISSUE, DRAIN, FIX, DONE.
- IDLE:
  - On req_valid, latch op, src1, src2, clear the accumulator, set cnt=0, go to ISSUE.
  - Inputs are ignored otherwise.
- ISSUE:
  - Drive the multiplier with partial product cnt, then cnt increments.
  - pp0 = A[15:0]*B[15:0], weighted by shift 0.
  - pp1 = A[31:16]*B[15:0], weighted by shift 16.
  - pp2 = A[15:0]*B[31:16], weighted by shift 16.
  - pp3 = A[31:16]*B[31:16], weighted by shift 32.
  - After the last pp, go to DRAIN.
- Multiplier: 32-bit product register, cleared by reset, loaded every cycle with an issued pp.
  - A valid flag travels with each product.
  - acc += product<<shift in the cycle after the pp is issued, mod 2^64.
- DRAIN: accumulate the final pp. Go to FIX for MULX ops and for MUL; see Configuration for the MUL exception.
- FIX, applied to acc[63:32] mod 2^32:
  - subtract B when op is MULXSU or MULXSS and A[31]=1;
  - subtract A when op is MULXSS and B[31]=1.
  - Then go to DONE.
- DONE:
  - M_mulx_result = acc[31:0] for MUL, acc[63:32] otherwise.
  - result_valid=1 for this cycle only.
  - Return to IDLE on the next edge.
- Abort:
  - Honoured in ISSUE, DRAIN and FIX: next state is IDLE, no result_valid, M_mulx_result unchanged.
  - In-flight product valid flag is cleared.
  - Ignored in IDLE and DONE.
- Abort and req_valid together in IDLE: the request is accepted.
- There is no back-pressure on the result. The consumer must take it in the DONE cycle.

## Timing
- Reset values:
  - state = IDLE.
  - M_mulx_req_ready = 1.
  - M_mulx_result_valid = 0.
  - M_mulx_result = 0.
  - acc = 0, product register = 0, cnt = 0.
- Cycle 0 is the acceptance cycle.
- Full path:
  - ISSUE in cycles 1-4.
  - DRAIN in cycle 5.
  - FIX in cycle 6.
  - DONE (result_valid) in cycle 7.
  - req_ready returns high in cycle 8.
- Throughput is one operation per 8 cycles. A back-to-back request can be accepted in cycle 8.
- req_ready is low from cycle 1 through DONE inclusive.
- Reset asserted mid-operation forces all reset values immediately. No result is produced.
- Abort asserted in cycle k (1≤k≤6) gives req_ready=1 in cycle k+1.

## Configuration
- Macro: TESTING_CPU_MULX_EARLY_OUT_EN.
- Defined: for op=MUL, ISSUE issues only pp0-pp2 (cycles 1-3), then DRAIN in cycle 4, skips FIX, and reaches DONE in cycle 5.
  - pp3 and the correction affect only bits [63:32], so the result is unchanged.
- Not defined: MUL follows the full 7-cycle path.
- MULX timing is identical in both builds.

## Test plan
- MULXUU 0xFFFFFFFF × 0xFFFFFFFF -> result 0xFFFFFFFE, result_valid in cycle 7, req_ready high in cycle 8.
- MULXSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF. MULXSS 0x80000000 × 0x80000000 -> 0x40000000. MULXSS 0xFFFFFFFF × 0x00000002 -> 0xFFFFFFFF.
- MUL 0x00010003 × 0x00020005 -> 0x000B000F.
  - result_valid in cycle 5 with TESTING_CPU_MULX_EARLY_OUT_EN defined.
  - result_valid in cycle 7 without it.
- MULXUU 5×7 with abort pulsed in cycle 3:
  - no result_valid is produced; req_ready=1 in cycle 4;
  - a new MULXUU 2×3 accepted in cycle 4 returns 0x00000000 with result_valid in cycle 11, and acc holds no residue from the aborted operation.
- reset_n driven low in cycle 2 of a MULXSS:
  - outputs take reset values immediately, with no result_valid;
  - after release, MULXSS 0xFFFFFFFF × 0xFFFFFFFF -> 0x00000000.
- Abort pulsed in the DONE cycle has no effect: result_valid still pulses. req_valid held high continuously gives exactly one acceptance per 8 cycles.
